// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit buffer with write-back, CDB broadcast and mispredict flush
// Optional feature macro: ROB_LSB_WB_EN adds the lsb_* write-back port.
// Ports: clk_in/rst_n_in clock and async active-low reset; rdy_in global stall;
//   issue_* allocate the entry at alloc_rob_id; full registered back-pressure;
//   rs_* (and lsb_*) write-back; query_* combinational operand lookup;
//   cdb_* registered commit broadcast; clear/clear_pc registered flush pulse and target.
module reorder_buffer #(
  parameter int ROB_CAP       = 16,
  parameter int ROB_INDEX_BIT = 4,
  parameter int FULL_MARGIN   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_req,
  input  logic                     issue_kind,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic [ROB_INDEX_BIT-1:0] alloc_rob_id,
  output logic                     full,
  input  logic                     rs_ready,
  input  logic [ROB_INDEX_BIT-1:0] rs_rob_id,
  input  logic [31:0]              rs_result,
`ifdef ROB_LSB_WB_EN
  input  logic                     lsb_ready,
  input  logic [ROB_INDEX_BIT-1:0] lsb_rob_id,
  input  logic [31:0]              lsb_result,
`endif
  input  logic [ROB_INDEX_BIT-1:0] query_id1,
  input  logic [ROB_INDEX_BIT-1:0] query_id2,
  output logic                     query_ready1,
  output logic                     query_ready2,
  output logic [31:0]              query_val1,
  output logic [31:0]              query_val2,
  output logic                     cdb_req,
  output logic [31:0]              cdb_val,
  output logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
  output logic [4:0]               cdb_rd,
  output logic                     clear,
  output logic [31:0]              clear_pc
);
  localparam int CW = ROB_INDEX_BIT + 1;
  logic [ROB_CAP-1:0] busy_q, busy_d, ready_q, ready_d, kind_q, kind_d, pred_q, pred_d;
  logic [4:0] rd_q [ROB_CAP];
  logic [4:0] rd_d [ROB_CAP];
  logic [31:0] val_q [ROB_CAP];
  logic [31:0] val_d [ROB_CAP];
  logic [31:0] alt_q [ROB_CAP];
  logic [31:0] alt_d [ROB_CAP];
  logic [ROB_INDEX_BIT-1:0] head_q, head_d, tail_q, tail_d, cdb_rob_id_q, cdb_rob_id_d;
  logic [CW-1:0] count_q, count_d;
  logic full_q, full_d, cdb_req_q, cdb_req_d, clear_q, clear_d;
  logic [31:0] cdb_val_q, cdb_val_d, clear_pc_q, clear_pc_d;
  logic [4:0] cdb_rd_q, cdb_rd_d;
  logic commit, mispredict, do_issue, rs_wb, lsb_wb;
  logic [ROB_INDEX_BIT-1:0] lsb_id;
  logic [31:0] lsb_val;
  // commit looks only at registered ready, so a same-edge write-back waits one cycle
  assign commit     = busy_q[head_q] & ready_q[head_q];
  assign mispredict = commit & kind_q[head_q] & (val_q[head_q][0] != pred_q[head_q]);
  assign do_issue   = issue_req & ~clear_q & ~mispredict;
  assign rs_wb      = rs_ready & ~clear_q & busy_q[rs_rob_id];
`ifdef ROB_LSB_WB_EN
  assign lsb_wb  = lsb_ready & ~clear_q & busy_q[lsb_rob_id];
  assign lsb_id  = lsb_rob_id;
  assign lsb_val = lsb_result;
`else
  assign lsb_wb  = 1'b0;
  assign lsb_id  = '0;
  assign lsb_val = '0;
`endif
  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    kind_d  = kind_q;
    pred_d  = pred_q;
    rd_d    = rd_q;
    val_d   = val_q;
    alt_d   = alt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    // lsb first so rs overrides it on a same-entry collision
    if (lsb_wb) begin
      val_d[lsb_id]   = lsb_val;
      ready_d[lsb_id] = 1'b1;
    end
    if (rs_wb) begin
      val_d[rs_rob_id]   = rs_result;
      ready_d[rs_rob_id] = 1'b1;
    end
    if (commit) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + ROB_INDEX_BIT'(1);
    end
    if (do_issue) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      kind_d[tail_q]  = issue_kind;
      pred_d[tail_q]  = issue_pred_taken;
      rd_d[tail_q]    = issue_rd;
      alt_d[tail_q]   = issue_alt_pc;
      tail_d          = tail_q + ROB_INDEX_BIT'(1);
    end
    if (mispredict) begin
      busy_d = '0;
      head_d = '0;
      tail_d = '0;
    end
    count_d      = mispredict ? '0 : count_q + CW'(do_issue) - CW'(commit);
    full_d       = count_d >= CW'(ROB_CAP - FULL_MARGIN);
    cdb_req_d    = commit & ~kind_q[head_q];
    cdb_val_d    = cdb_req_d ? val_q[head_q] : cdb_val_q;
    cdb_rob_id_d = cdb_req_d ? head_q : cdb_rob_id_q;
    cdb_rd_d     = cdb_req_d ? rd_q[head_q] : cdb_rd_q;
    clear_d      = mispredict;
    clear_pc_d   = mispredict ? alt_q[head_q] : clear_pc_q;
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q       <= '0;
      ready_q      <= '0;
      kind_q       <= '0;
      pred_q       <= '0;
      for (int i = 0; i < ROB_CAP; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        alt_q[i] <= '0;
      end
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      cdb_req_q    <= 1'b0;
      cdb_val_q    <= '0;
      cdb_rob_id_q <= '0;
      cdb_rd_q     <= '0;
      clear_q      <= 1'b0;
      clear_pc_q   <= '0;
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      kind_q       <= kind_d;
      pred_q       <= pred_d;
      rd_q         <= rd_d;
      val_q        <= val_d;
      alt_q        <= alt_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      full_q       <= full_d;
      cdb_req_q    <= cdb_req_d;
      cdb_val_q    <= cdb_val_d;
      cdb_rob_id_q <= cdb_rob_id_d;
      cdb_rd_q     <= cdb_rd_d;
      clear_q      <= clear_d;
      clear_pc_q   <= clear_pc_d;
    end else begin
      cdb_req_q    <= 1'b0;
      clear_q      <= 1'b0;
    end
  end
  assign alloc_rob_id = tail_q;
  assign full         = full_q;
  assign query_ready1 = busy_q[query_id1] & ready_q[query_id1];
  assign query_ready2 = busy_q[query_id2] & ready_q[query_id2];
  assign query_val1   = val_q[query_id1];
  assign query_val2   = val_q[query_id2];
  assign cdb_req      = cdb_req_q;
  assign cdb_val      = cdb_val_q;
  assign cdb_rob_id   = cdb_rob_id_q;
  assign cdb_rd       = cdb_rd_q;
  assign clear        = clear_q;
  assign clear_pc     = clear_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus against a queue-based program-order model of the ROB
module tb_reorder_buffer;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic rdy_in = 1'b1;
  logic issue_req = 1'b0, issue_kind = 1'b0, issue_pred_taken = 1'b0;
  logic [4:0] issue_rd = '0;
  logic [31:0] issue_alt_pc = '0;
  logic [3:0] alloc_rob_id;
  logic full;
  logic rs_ready = 1'b0;
  logic [3:0] rs_rob_id = '0;
  logic [31:0] rs_result = '0;
`ifdef ROB_LSB_WB_EN
  logic lsb_ready = 1'b0;
  logic [3:0] lsb_rob_id = '0;
  logic [31:0] lsb_result = '0;
`endif
  logic [3:0] query_id1 = '0, query_id2 = '0;
  logic query_ready1, query_ready2;
  logic [31:0] query_val1, query_val2;
  logic cdb_req, clear;
  logic [31:0] cdb_val, clear_pc;
  logic [3:0] cdb_rob_id;
  logic [4:0] cdb_rd;
  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_req(issue_req), .issue_kind(issue_kind), .issue_rd(issue_rd),
    .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
    .alloc_rob_id(alloc_rob_id), .full(full),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_result(rs_result),
`ifdef ROB_LSB_WB_EN
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_result(lsb_result),
`endif
    .query_id1(query_id1), .query_id2(query_id2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_val1(query_val1), .query_val2(query_val2),
    .cdb_req(cdb_req), .cdb_val(cdb_val), .cdb_rob_id(cdb_rob_id), .cdb_rd(cdb_rd),
    .clear(clear), .clear_pc(clear_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0]  id;
    logic        kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        rdy;
    logic        pred;
    logic [31:0] alt;
  } ent_t;
  ent_t q[$];
  ent_t h;
  logic [3:0] m_tail, m_id;
  logic [4:0] m_rd;
  logic [31:0] m_val, m_cpc;
  logic m_req, m_clear, m_full, com, mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // program-order model: a queue of in-flight instructions, oldest first
  task model_step();
    if (!rst_n_in) begin
      q.delete();
      m_tail = '0; m_id = '0; m_rd = '0; m_val = '0; m_cpc = '0;
      m_req = 1'b0; m_clear = 1'b0; m_full = 1'b0;
    end else if (!rdy_in) begin
      m_req = 1'b0;
      m_clear = 1'b0;
    end else begin
      com = q.size() > 0 && q[0].rdy;
      if (com) h = q[0];
      if (!m_clear) begin
`ifdef ROB_LSB_WB_EN
        if (lsb_ready) foreach (q[i]) if (q[i].id == lsb_rob_id) begin q[i].val = lsb_result; q[i].rdy = 1'b1; end
`endif
        if (rs_ready) foreach (q[i]) if (q[i].id == rs_rob_id) begin q[i].val = rs_result; q[i].rdy = 1'b1; end
      end
      mis = com && h.kind && (h.val[0] != h.pred);
      m_req = com && !h.kind;
      if (m_req) begin m_val = h.val; m_id = h.id; m_rd = h.rd; end
      if (com) void'(q.pop_front());
      if (mis) begin
        q.delete();
        m_tail = '0;
        m_cpc = h.alt;
      end else if (issue_req && !m_clear) begin
        q.push_back('{m_tail, issue_kind, issue_rd, 32'h0, 1'b0, issue_pred_taken, issue_alt_pc});
        m_tail = m_tail + 4'd1;
      end
      m_clear = mis;
      m_full = q.size() >= 14;
    end
  endtask

  function automatic logic m_qready(input logic [3:0] id, output logic [31:0] v);
    v = '0;
    foreach (q[i]) if (q[i].id == id && q[i].rdy) begin v = q[i].val; return 1'b1; end
    return 1'b0;
  endfunction

  task compare();
    logic [31:0] v1, v2;
    logic r1, r2;
    r1 = m_qready(query_id1, v1);
    r2 = m_qready(query_id2, v2);
    check("cdb_req", 32'(cdb_req), 32'(m_req));
    check("cdb_val", cdb_val, m_val);
    check("cdb_rob_id", 32'(cdb_rob_id), 32'(m_id));
    check("cdb_rd", 32'(cdb_rd), 32'(m_rd));
    check("clear", 32'(clear), 32'(m_clear));
    check("clear_pc", clear_pc, m_cpc);
    check("full", 32'(full), 32'(m_full));
    check("alloc_rob_id", 32'(alloc_rob_id), 32'(m_tail));
    check("query_ready1", 32'(query_ready1), 32'(r1));
    check("query_ready2", 32'(query_ready2), 32'(r2));
    if (r1) check("query_val1", query_val1, v1);
    if (r2) check("query_val2", query_val2, v2);
  endtask

  always @(posedge clk_in or negedge rst_n_in) model_step();
  always @(negedge clk_in) if (rst_n_in) compare();

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic k, input logic [4:0] rd, input logic p, input logic [31:0] a);
    issue_req = 1'b1; issue_kind = k; issue_rd = rd; issue_pred_taken = p; issue_alt_pc = a;
    tick();
    issue_req = 1'b0;
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] v);
    rs_ready = 1'b1; rs_rob_id = id; rs_result = v;
    tick();
    rs_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    #2;
    check("rst full", 32'(full), 0);
    check("rst cdb_req", 32'(cdb_req), 0);
    check("rst cdb_val", cdb_val, 0);
    check("rst cdb_rob_id", 32'(cdb_rob_id), 0);
    check("rst cdb_rd", 32'(cdb_rd), 0);
    check("rst clear", 32'(clear), 0);
    check("rst clear_pc", clear_pc, 0);
    check("rst alloc", 32'(alloc_rob_id), 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  initial begin
    do_reset();
    // single REG write-back and commit latency
    check("A alloc", 32'(alloc_rob_id), 0);
    issue(1'b0, 5'd3, 1'b0, 32'h0);
    wb(4'd0, 32'h1234);
    check("A cdb_req at E", 32'(cdb_req), 0);
    tick();
    check("A cdb_req at E+1", 32'(cdb_req), 1);
    check("A cdb_val", cdb_val, 32'h1234);
    check("A cdb_rd", 32'(cdb_rd), 3);
    check("A cdb_rob_id", 32'(cdb_rob_id), 0);
    tick();
    check("A cdb_req drop", 32'(cdb_req), 0);
    // out-of-order write-back, in-order commit; stray write-back to an idle entry
    do_reset();
    wb(4'd5, 32'h99);
    query_id2 = 4'd5;
    check("B stray wb ignored", 32'(query_ready2), 0);
    for (int i = 0; i < 3; i++) issue(1'b0, 5'(i + 1), 1'b0, 32'h0);
    wb(4'd2, 32'h102);
    wb(4'd1, 32'h101);
    wb(4'd0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("B cdb_req", 32'(cdb_req), 1);
      check("B cdb_rob_id", 32'(cdb_rob_id), 32'(i));
      check("B cdb_val", cdb_val, 32'h100 + 32'(i));
    end
    tick();
    check("B cdb_req drop", 32'(cdb_req), 0);
    // fill to the full threshold twice, wrapping the tail
    do_reset();
    for (int i = 0; i < 14; i++) begin
      issue(1'b0, 5'd1, 1'b0, 32'h0);
      if (i == 12) check("C full at 13", 32'(full), 0);
    end
    check("C full at 14", 32'(full), 1);
    wb(4'd0, 32'h7);
    check("C full before commit", 32'(full), 1);
    tick();
    check("C full after commit", 32'(full), 0);
    for (int j = 1; j < 14; j++) wb(4'(j), 32'(j));
    repeat (3) tick();
    check("C alloc after drain", 32'(alloc_rob_id), 14);
    for (int i = 0; i < 14; i++) begin
      issue(1'b0, 5'd2, 1'b0, 32'h0);
      if (i == 1) check("C tail wrap", 32'(alloc_rob_id), 0);
    end
    check("C full second fill", 32'(full), 1);
    for (int j = 0; j < 14; j++) wb(4'(14 + j), 32'h500 + 32'(j));
    repeat (3) tick();
    // mispredicted branch with younger entries and a same-cycle issue
    do_reset();
    issue(1'b1, 5'd0, 1'b1, 32'h80);
    for (int i = 0; i < 3; i++) issue(1'b0, 5'd5, 1'b0, 32'h0);
    query_id1 = 4'd1;
    query_id2 = 4'd0;
    wb(4'd1, 32'h55);
    wb(4'd0, 32'h0);
    check("E query_ready1", 32'(query_ready1), 1);
    check("E query_val1", query_val1, 32'h55);
    issue_req = 1'b1; issue_kind = 1'b0; issue_rd = 5'd7;
    tick();
    check("E clear", 32'(clear), 1);
    check("E clear_pc", clear_pc, 32'h80);
    check("E alloc", 32'(alloc_rob_id), 0);
    check("E no cdb", 32'(cdb_req), 0);
    check("E flushed", 32'(query_ready1), 0);
    rs_ready = 1'b1; rs_rob_id = 4'd0; rs_result = 32'h9;
    tick();
    issue_req = 1'b0;
    rs_ready = 1'b0;
    check("E clear pulse", 32'(clear), 0);
    check("E issue ignored", 32'(alloc_rob_id), 0);
    check("E wb ignored", 32'(query_ready2), 0);
    issue(1'b0, 5'd4, 1'b0, 32'h0);
    check("E realloc", 32'(alloc_rob_id), 1);
    wb(4'd0, 32'h77);
    tick();
    check("E recommit id", 32'(cdb_rob_id), 0);
    check("E recommit val", cdb_val, 32'h77);
    // correctly predicted branch retires silently
    issue(1'b1, 5'd0, 1'b0, 32'h200);
    wb(4'd1, 32'h2);
    tick();
    check("D silent cdb", 32'(cdb_req), 0);
    check("D no clear", 32'(clear), 0);
    check("D clear_pc held", clear_pc, 32'h80);
    // stall with rdy_in low
    issue(1'b0, 5'd9, 1'b0, 32'h0);
    wb(4'd2, 32'hBEEF);
    rdy_in = 1'b0;
    tick();
    tick();
    check("F stalled", 32'(cdb_req), 0);
    rdy_in = 1'b1;
    tick();
    check("F cdb_req", 32'(cdb_req), 1);
    check("F cdb_val", cdb_val, 32'hBEEF);
    check("F cdb_rd", 32'(cdb_rd), 9);
    // asynchronous reset with five busy entries
    for (int i = 0; i < 5; i++) issue(1'b0, 5'd6, 1'b0, 32'h0);
    check("H alloc before", 32'(alloc_rob_id), 8);
    do_reset();
    check("H alloc after", 32'(alloc_rob_id), 0);
    check("H full after", 32'(full), 0);
`ifdef ROB_LSB_WB_EN
    // both write-back ports hit entry 4; rs wins
    for (int i = 0; i < 5; i++) issue(1'b0, 5'd8, 1'b0, 32'h0);
    lsb_ready = 1'b1; lsb_rob_id = 4'd0; lsb_result = 32'h30;
    tick();
    lsb_ready = 1'b0;
    for (int j = 1; j < 4; j++) wb(4'(j), 32'h30 + 32'(j));
    lsb_ready = 1'b1; lsb_rob_id = 4'd4; lsb_result = 32'hB;
    wb(4'd4, 32'hA);
    lsb_ready = 1'b0;
    tick();
    check("G cdb_rob_id", 32'(cdb_rob_id), 4);
    check("G cdb_val", cdb_val, 32'hA);
`endif
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
